// File: rtl/pipe_chain.sv
// Purpose : in-order pipeline register chain (instr/pc/dst/payload) with late result injection and forwarding lookup.
// Latency : an input appears on stage k outputs after k+1 clock edges; forwarding outputs are combinational.
// Backpr. : stall holds stage 0 and inserts a bubble into stage 1; flush squashes stage 0. Optional macro PIPE_CHAIN_PERF_EN adds perf_bubbles.
module pipe_chain #(
   parameter int W     = 32,
   parameter int DEPTH = 3,
   parameter int NDATA = 2,
   parameter int REGW  = 5,
   parameter int NQ    = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   input  logic [W-1:0]             in_instr,
   input  logic [W-1:0]             in_pc,
   input  logic [NDATA*W-1:0]       in_data,
   input  logic                     in_wen,
   input  logic [REGW-1:0]          in_dst,
   input  logic                     in_rdy,
   input  logic                     stall,
   input  logic                     flush,
   input  logic [DEPTH-1:0]         upd_en,
   input  logic [DEPTH*W-1:0]       upd_val,
   input  logic [NQ*REGW-1:0]       q_addr,
   output logic [DEPTH-1:0]         st_valid,
   output logic [DEPTH*W-1:0]       st_instr,
   output logic [DEPTH*W-1:0]       st_pc,
   output logic [DEPTH*NDATA*W-1:0] st_data,
   output logic [NQ-1:0]            q_hit,
   output logic [NQ-1:0]            q_rdy,
   output logic [NQ*W-1:0]          q_val
`ifdef PIPE_CHAIN_PERF_EN
   ,
   output logic [31:0]              perf_bubbles
`endif
);

   typedef struct packed {
      logic               valid;
      logic               wen;
      logic               rdy;
      logic [REGW-1:0]    dst;
      logic [W-1:0]       instr;
      logic [W-1:0]       pc;
      logic [NDATA*W-1:0] data;   // word 0 in the low W bits is the result slot
   } stage_t;

   stage_t           st_q [DEPTH];
   stage_t           st_d [DEPTH];
   logic [DEPTH-1:0] upd_eff;

   // The last stage has no successor, so its update strobe never takes effect.
   assign upd_eff = upd_en & {1'b0, {(DEPTH-1){1'b1}}};

   // Next-state for every stage: stage 0 load/hold/squash, later stages shift with optional word-0 injection.
   always_comb begin
      st_d[0] = st_q[0];
      if (flush) begin
         st_d[0] = '0;
      end else if (!stall) begin
         st_d[0].valid = in_valid;
         st_d[0].wen   = in_wen;
         st_d[0].rdy   = in_rdy;
         st_d[0].dst   = in_dst;
         st_d[0].instr = in_instr;
         st_d[0].pc    = in_pc;
         st_d[0].data  = in_data;
      end
      for (int k = 1; k < DEPTH; k++) begin
         st_d[k] = st_q[k-1];
         if (upd_eff[k-1]) begin
            st_d[k].data[W-1:0] = upd_val[(k-1)*W +: W];
            // an injected value only marks a real instruction as final
            st_d[k].rdy = st_q[k-1].rdy | st_q[k-1].valid;
         end
      end
      if (stall) begin
         st_d[1] = '0;
      end
   end

   // Stage registers; reset dominates stall, flush and update.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < DEPTH; k++) begin
            st_q[k] <= '0;
         end
      end else begin
         st_q <= st_d;
      end
   end

   // Flatten stage contents onto the output buses; a bubble's instr reads as 0.
   always_comb begin
      st_valid = '0;
      st_instr = '0;
      st_pc    = '0;
      st_data  = '0;
      for (int k = 0; k < DEPTH; k++) begin
         st_valid[k]                      = st_q[k].valid;
         st_instr[k*W +: W]               = st_q[k].valid ? st_q[k].instr : '0;
         st_pc[k*W +: W]                  = st_q[k].pc;
         st_data[k*NDATA*W +: NDATA*W]    = st_q[k].data;
      end
   end

   // Forwarding lookup: scan oldest to youngest so the youngest match is the last one written.
   always_comb begin
      q_hit = '0;
      q_rdy = '1;
      q_val = '0;
      for (int qi = 0; qi < NQ; qi++) begin
         for (int k = DEPTH-1; k >= 0; k--) begin
            if (st_q[k].valid && st_q[k].wen &&
                (st_q[k].dst == q_addr[qi*REGW +: REGW]) &&
                (q_addr[qi*REGW +: REGW] != '0)) begin
               q_hit[qi]         = 1'b1;
               q_rdy[qi]         = st_q[k].rdy | upd_eff[k];
               q_val[qi*W +: W]  = upd_eff[k] ? upd_val[k*W +: W] : st_q[k].data[W-1:0];
            end
         end
      end
   end

`ifdef PIPE_CHAIN_PERF_EN
   logic st0_flushed_q;
   logic bubble_load;

   // Stage 1 takes a bubble this cycle on stall or when stage 0 holds a squashed entry.
   assign bubble_load = stall | st0_flushed_q;

   // Remember whether stage 0 currently holds a flushed bubble.
   always_ff @(posedge clk) begin
      if (rst) begin
         st0_flushed_q <= 1'b0;
      end else if (flush) begin
         st0_flushed_q <= 1'b1;
      end else if (!stall) begin
         st0_flushed_q <= 1'b0;
      end
   end

   // Saturating bubble counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         perf_bubbles <= '0;
      end else if (bubble_load && (perf_bubbles != 32'hFFFF_FFFF)) begin
         perf_bubbles <= perf_bubbles + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_pipe_chain.sv
// Purpose : directed checks of pipe_chain flow, stall/flush, forwarding and optional bubble counter.
// Latency : stimulus applied #1 after a rising edge, outputs sampled before the next edge.
// Backpr. : exercises stall and flush directly.
module tb_pipe_chain;

   localparam int W     = 32;
   localparam int DEPTH = 3;
   localparam int NDATA = 2;
   localparam int REGW  = 5;
   localparam int NQ    = 2;

   logic                     clk = 1'b0;
   logic                     rst;
   logic                     in_valid;
   logic [W-1:0]             in_instr;
   logic [W-1:0]             in_pc;
   logic [NDATA*W-1:0]       in_data;
   logic                     in_wen;
   logic [REGW-1:0]          in_dst;
   logic                     in_rdy;
   logic                     stall;
   logic                     flush;
   logic [DEPTH-1:0]         upd_en;
   logic [DEPTH*W-1:0]       upd_val;
   logic [NQ*REGW-1:0]       q_addr;
   logic [DEPTH-1:0]         st_valid;
   logic [DEPTH*W-1:0]       st_instr;
   logic [DEPTH*W-1:0]       st_pc;
   logic [DEPTH*NDATA*W-1:0] st_data;
   logic [NQ-1:0]            q_hit;
   logic [NQ-1:0]            q_rdy;
   logic [NQ*W-1:0]          q_val;
`ifdef PIPE_CHAIN_PERF_EN
   logic [31:0]              perf_bubbles;
`endif

   int n_chk  = 0;
   int n_pass = 0;

   pipe_chain #(.W(W), .DEPTH(DEPTH), .NDATA(NDATA), .REGW(REGW), .NQ(NQ)) dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_instr (in_instr),
      .in_pc    (in_pc),
      .in_data  (in_data),
      .in_wen   (in_wen),
      .in_dst   (in_dst),
      .in_rdy   (in_rdy),
      .stall    (stall),
      .flush    (flush),
      .upd_en   (upd_en),
      .upd_val  (upd_val),
      .q_addr   (q_addr),
      .st_valid (st_valid),
      .st_instr (st_instr),
      .st_pc    (st_pc),
      .st_data  (st_data),
      .q_hit    (q_hit),
      .q_rdy    (q_rdy),
      .q_val    (q_val)
`ifdef PIPE_CHAIN_PERF_EN
      ,
      .perf_bubbles (perf_bubbles)
`endif
   );

   always #5 clk = ~clk;

   // Watchdog so the run always terminates.
   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic feed(input logic v, input logic [31:0] instr, input logic [31:0] pc,
                       input logic wen, input logic [4:0] dst, input logic rdy,
                       input logic [31:0] d0, input logic [31:0] d1);
      in_valid = v;
      in_instr = instr;
      in_pc    = pc;
      in_wen   = wen;
      in_dst   = dst;
      in_rdy   = rdy;
      in_data  = {d1, d0};
   endtask

   function automatic logic [31:0] pc_of(input int k);
      return st_pc[k*W +: W];
   endfunction

   function automatic logic [31:0] instr_of(input int k);
      return st_instr[k*W +: W];
   endfunction

   function automatic logic [31:0] dw(input int k, input int j);
      return st_data[(k*NDATA+j)*W +: W];
   endfunction

   initial begin
      // ---------------- reset with a live input held at stage 0 ----------------
      rst = 1'b1; stall = 1'b0; flush = 1'b0; upd_en = '0; upd_val = '0;
      feed(1'b1, 32'hDEADBEEF, 32'h1234, 1'b1, 5'd3, 1'b1, 32'h1, 32'h2);
      q_addr = {5'd3, 5'd3};
      step(); step();
      chk("rst_valid", {29'd0, st_valid}, 32'd0);
      chk("rst_qhit",  {30'd0, q_hit},    32'd0);
      chk("rst_qval0", q_val[31:0],       32'd0);
      chk("rst_pc0",   pc_of(0),          32'd0);
      chk("rst_data0", dw(0, 0),          32'd0);
`ifdef PIPE_CHAIN_PERF_EN
      chk("rst_perf",  perf_bubbles,      32'd0);
`endif

      // ---------------- straight flow, 3-stage latency ----------------
      rst = 1'b0; q_addr = '0;
      feed(1'b1, 32'h00221820, 32'h3000, 1'b0, 5'd0, 1'b0, 32'hA0, 32'hB0);
      step();
      chk("flow1_valid", {29'd0, st_valid}, 32'b001);
      chk("flow1_pc0",   pc_of(0),          32'h3000);
      feed(1'b1, 32'h00431020, 32'h3004, 1'b0, 5'd0, 1'b0, 32'hA4, 32'hB4);
      step();
      feed(1'b1, 32'h00641820, 32'h3008, 1'b0, 5'd0, 1'b0, 32'hA8, 32'hB8);
      step();
      chk("flow_valid",  {29'd0, st_valid}, 32'b111);
      chk("flow_pc2",    pc_of(2),          32'h3000);
      chk("flow_pc1",    pc_of(1),          32'h3004);
      chk("flow_pc0",    pc_of(0),          32'h3008);
      chk("flow_instr2", instr_of(2),       32'h00221820);
      chk("flow_d2w0",   dw(2, 0),          32'hA0);
      chk("flow_d2w1",   dw(2, 1),          32'hB0);

      // ---------------- stall: stage 0 holds 0x3004, bubble into stage 1 ----------------
      feed(1'b1, 32'h00851020, 32'h3004, 1'b0, 5'd0, 1'b0, 32'hC4, 32'hD4);
      step();   // stages: 3004 / 3008 / 3004
      stall = 1'b1;
      feed(1'b1, 32'h00A61820, 32'h300C, 1'b0, 5'd0, 1'b0, 32'hAC, 32'hBC);
      step();   // stages: 3004 / bubble / 3008
      chk("stall_pc0",    pc_of(0),        32'h3004);
      chk("stall_v1",     {31'd0, st_valid[1]}, 32'd0);
      chk("stall_instr1", instr_of(1),     32'd0);
      chk("stall_pc2",    pc_of(2),        32'h3008);
      stall = 1'b0;
      step();   // stages: 300C / 3004 / bubble
      chk("unstall_pc1",  pc_of(1),        32'h3004);
      chk("unstall_d1w0", dw(1, 0),        32'hC4);
      chk("unstall_pc0",  pc_of(0),        32'h300C);
      chk("unstall_valid",{29'd0, st_valid}, 32'b011);

      // ---------------- flush together with stall ----------------
      stall = 1'b1; flush = 1'b1;
      feed(1'b1, 32'h11111111, 32'h3010, 1'b0, 5'd0, 1'b0, 32'h0, 32'h0);
      step();   // stages: bubble / bubble / 3004
      chk("fs_valid", {29'd0, st_valid}, 32'b100);
      chk("fs_pc2",   pc_of(2),          32'h3004);
      chk("fs_pc0",   pc_of(0),          32'd0);
      stall = 1'b0; flush = 1'b0;
      feed(1'b1, 32'h22222222, 32'h3018, 1'b0, 5'd0, 1'b0, 32'h0, 32'h0);
      step();   // stages: 3018 / bubble / bubble
      flush = 1'b1;
      feed(1'b1, 32'h33333333, 32'h301C, 1'b0, 5'd0, 1'b0, 32'h0, 32'h0);
      step();   // stages: bubble / 3018 / bubble
      chk("flush_valid", {29'd0, st_valid}, 32'b010);
      chk("flush_pc1",   pc_of(1),          32'h3018);
      flush = 1'b0;

      // ---------------- bubble counter: 5 stalls + 2 flushes ----------------
      rst = 1'b1; step(); rst = 1'b0;
      feed(1'b1, 32'h44444444, 32'h3100, 1'b0, 5'd0, 1'b0, 32'h0, 32'h0);
      for (int i = 0; i < 5; i++) begin
         stall = 1'b1; step();
         stall = 1'b0; step();
      end
      for (int i = 0; i < 2; i++) begin
         flush = 1'b1; step();
         flush = 1'b0; step();
      end
`ifdef PIPE_CHAIN_PERF_EN
      chk("perf_bubbles", perf_bubbles, 32'd7);
`endif

      // ---------------- forwarding with late result injection ----------------
      rst = 1'b1; step(); rst = 1'b0;
      feed(1'b1, 32'h00000001, 32'h4000, 1'b1, 5'd3, 1'b1, 32'h11, 32'hB1);
      step();
      feed(1'b1, 32'h00000002, 32'h4004, 1'b1, 5'd3, 1'b0, 32'h55, 32'hB2);
      step();
      feed(1'b1, 32'h00000003, 32'h4008, 1'b1, 5'd7, 1'b1, 32'h77, 32'hB3);
      step();   // stages: 4008(r7) / 4004(r3,!rdy) / 4000(r3,rdy)
      q_addr = {5'd7, 5'd3};
      #1;
      chk("fwd_hit",   {30'd0, q_hit}, 32'b11);
      chk("fwd_rdy",   {30'd0, q_rdy}, 32'b10);
      chk("fwd_val0",  q_val[31:0],    32'h55);
      chk("fwd_val1",  q_val[63:32],   32'h77);
      upd_en  = 3'b010;
      upd_val = {32'h0, 32'h22, 32'hDEAD};
      #1;
      chk("byp_rdy",   {30'd0, q_rdy}, 32'b11);
      chk("byp_val0",  q_val[31:0],    32'h22);
      stall = 1'b1;
      step();   // stages: 4008 / bubble / 4004 with word0 injected
      stall = 1'b0; upd_en = '0; upd_val = '0;
      #1;
      chk("inj_d2w0",  dw(2, 0),       32'h22);
      chk("inj_d2w1",  dw(2, 1),       32'hB2);
      chk("inj_hit",   {30'd0, q_hit}, 32'b11);
      chk("inj_rdy",   {30'd0, q_rdy}, 32'b11);
      chk("inj_val0",  q_val[31:0],    32'h22);

      // ---------------- register 0 and stale-dst bubbles never match ----------------
      rst = 1'b1; step(); rst = 1'b0;
      feed(1'b1, 32'h00000004, 32'h5000, 1'b1, 5'd0, 1'b1, 32'h99, 32'h0);
      q_addr = {5'd0, 5'd0};
      step();
      chk("r0_hit",    {30'd0, q_hit}, 32'b00);
      chk("r0_rdy",    {30'd0, q_rdy}, 32'b11);
      chk("r0_val0",   q_val[31:0],    32'd0);
      feed(1'b0, 32'h00000005, 32'h5004, 1'b1, 5'd3, 1'b1, 32'h88, 32'h0);
      q_addr = {5'd3, 5'd0};
      step();   // stages: invalid(r3) / valid(r0) / bubble
      chk("bub_hit",   {30'd0, q_hit}, 32'b00);
      chk("bub_val1",  q_val[63:32],   32'd0);
      chk("bub_valid", {29'd0, st_valid}, 32'b010);
      chk("bub_instr0",instr_of(0),    32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
